// File: rtl/mem_req_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_req_initiator : LSU-side initiator of the mem_pkt_t valid/ready link.   |
// |   One load/store in flight, misalignment trap, read timeout with drain.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+

package mem_pkt_pkg;
   typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_mtype_e;

   typedef struct packed {
      mem_mtype_e  mtype;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_pkt_t;
endpackage

module mem_req_initiator
   import mem_pkt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_vld,
   output logic        o_req_rdy,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_vld,
   input  logic        i_rsp_rdy,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_misaligned,
   output logic        o_rsp_err,
   output logic        o_pkt_out_vld,
   input  logic        i_pkt_out_rdy,
   output mem_pkt_t    o_pkt_out,
   input  logic        i_pkt_in_vld,
   output logic        o_pkt_in_rdy,
   input  mem_pkt_t    i_pkt_in
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_drain;
   logic [2:0]       r_funct3;
   mem_pkt_t         r_pkt;
   logic             r_pkt_vld;
   logic             r_rsp_vld;
   logic [31:0]      r_rdata;
   logic             r_mis;
   logic             r_err;

   logic             w_misaligned;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_timeout;
   logic [31:0]      w_ext;
   logic             w_unused;

   // size 3 is not a legal RV access; it is trapped like a word
   assign w_misaligned = ((i_req_funct3[1:0] == 2'd1) && i_req_addr[0]) ||
                         (i_req_funct3[1] && (i_req_addr[1:0] != 2'd0));

   assign w_cnt_nxt = r_cnt + 1'b1;
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES));

   always_comb begin
      w_ext = i_pkt_in.data;
      case (r_funct3[1:0])
         2'd0:    w_ext = {{24{i_pkt_in.data[7] & ~r_funct3[2]}}, i_pkt_in.data[7:0]};
         2'd1:    w_ext = {{16{i_pkt_in.data[15] & ~r_funct3[2]}}, i_pkt_in.data[15:0]};
         default: w_ext = i_pkt_in.data;
      endcase
   end

   assign w_unused = ^{i_pkt_in.mtype, i_pkt_in.addr, i_pkt_in.len};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_drain   <= 1'b0;
         r_funct3  <= 3'd0;
         r_pkt     <= '0;
         r_pkt_vld <= 1'b0;
         r_rsp_vld <= 1'b0;
         r_rdata   <= 32'd0;
         r_mis     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         // a stale read response after a timeout is swallowed wherever it lands
         if (r_drain && i_pkt_in_vld)
            r_drain <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (i_req_vld && !r_drain) begin
                  r_funct3    <= i_req_funct3;
                  r_pkt.mtype <= i_req_we ? MEM_WRITE : MEM_READ;
                  r_pkt.addr  <= i_req_addr;
                  r_pkt.len   <= i_req_funct3[1:0];
                  r_pkt.data  <= i_req_we ? i_req_wdata : 32'd0;
                  if (w_misaligned) begin
                     r_mis     <= 1'b1;
                     r_rdata   <= 32'd0;
                     r_rsp_vld <= 1'b1;
                     r_state   <= S_RESP;
                  end else begin
                     r_pkt_vld <= 1'b1;
                     r_state   <= S_SEND;
                  end
               end
            end
            S_SEND: begin
               if (i_pkt_out_rdy) begin
                  r_pkt_vld <= 1'b0;
                  if (r_pkt.mtype == MEM_WRITE) begin
                     r_rdata   <= 32'd0;
                     r_rsp_vld <= 1'b1;
                     r_state   <= S_RESP;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (i_pkt_in_vld) begin
                  r_rdata   <= w_ext;
                  r_rsp_vld <= 1'b1;
                  r_state   <= S_RESP;
               end else if (w_timeout) begin
                  r_err     <= 1'b1;
                  r_rdata   <= 32'd0;
                  r_rsp_vld <= 1'b1;
                  r_drain   <= 1'b1;
                  r_state   <= S_RESP;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            S_RESP: begin
               if (i_rsp_rdy) begin
                  r_rsp_vld <= 1'b0;
                  r_mis     <= 1'b0;
                  r_err     <= 1'b0;
                  r_rdata   <= 32'd0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_rdy        = (r_state == S_IDLE) && !r_drain;
   assign o_pkt_in_rdy     = (r_state == S_WAIT) || r_drain;
   assign o_pkt_out_vld    = r_pkt_vld;
   assign o_pkt_out        = r_pkt;
   assign o_rsp_vld        = r_rsp_vld;
   assign o_rsp_rdata      = r_rdata;
   assign o_rsp_misaligned = r_mis;
   assign o_rsp_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_req_initiator : randomized and directed bench for mem_req_initiator |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+

module tb_mem_req_initiator;
   import mem_pkt_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req_vld, i_req_we, i_rsp_rdy, i_pkt_out_rdy, i_pkt_in_vld;
   logic [31:0] i_req_addr, i_req_wdata;
   logic [2:0]  i_req_funct3;
   mem_pkt_t    i_pkt_in;
   logic        o_req_rdy, o_rsp_vld, o_rsp_misaligned, o_rsp_err, o_pkt_out_vld, o_pkt_in_rdy;
   logic [31:0] o_rsp_rdata;
   mem_pkt_t    o_pkt_out;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_req_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_funct3(i_req_funct3), .i_req_wdata(i_req_wdata),
      .o_rsp_vld(o_rsp_vld), .i_rsp_rdy(i_rsp_rdy), .o_rsp_rdata(o_rsp_rdata),
      .o_rsp_misaligned(o_rsp_misaligned), .o_rsp_err(o_rsp_err),
      .o_pkt_out_vld(o_pkt_out_vld), .i_pkt_out_rdy(i_pkt_out_rdy), .o_pkt_out(o_pkt_out),
      .i_pkt_in_vld(i_pkt_in_vld), .o_pkt_in_rdy(o_pkt_in_rdy), .i_pkt_in(i_pkt_in)
   );

   typedef struct {
      bit          done;
      int          acc_cyc;
      int          pkt_cyc;
      mem_pkt_t    pkt;
      int          rsp_cyc;
      logic [31:0] rdata;
      logic        mis;
      logic        err;
      int          unstable;
      int          rdy_busy;
      int          inrdy_bad;
      bit          late;
   } obs_t;

   // ---------------- reference model ----------------
   function automatic bit m_misaligned(logic [31:0] addr, logic [2:0] f3);
      int sz;
      sz = 1 << f3[1:0];
      return (addr % sz) != 0;
   endfunction

   function automatic logic [31:0] m_extend(logic [2:0] f3, logic [31:0] d);
      longint v;
      if (f3[1:0] == 2'd0) begin
         v = longint'(d % 256);
         if (!f3[2] && v >= 128) v = v - 256;
      end else if (f3[1:0] == 2'd1) begin
         v = longint'(d % 65536);
         if (!f3[2] && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(d);
      end
      return v[31:0];
   endfunction

   function automatic int m_rsp_cyc(logic we, bit mis, int acc, int pdly, int mdly);
      int h;
      h = acc + 1 + pdly;
      if (mis)       return acc + 1;
      if (we)        return h + 1;
      if (mdly < TO) return h + 2 + mdly;
      return h + 1 + TO;
   endfunction

   // ---------------- protocol driver (observes only) ----------------
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] md, input int pdly,
                          input int mdly, input int cdly, output obs_t o);
      int pw, cw, mw;
      bit pkt_hs, rsp_hs, in_hs, pkt_done, rsp_done, mem_armed, mem_done;
      o = '{default: 0};
      o.acc_cyc = -1; o.pkt_cyc = -1; o.rsp_cyc = -1;
      pw = 0; cw = 0; mw = 0;
      pkt_hs = 0; rsp_hs = 0; in_hs = 0; pkt_done = 0; rsp_done = 0; mem_armed = 0; mem_done = 0;
      @(negedge clk);
      i_req_vld = 1'b1; i_req_we = we; i_req_addr = addr; i_req_funct3 = f3; i_req_wdata = wd;
      for (int k = 0; k < 50 && !o_req_rdy; k++) @(negedge clk);
      if (!o_req_rdy) begin
         i_req_vld = 1'b0;
         return;
      end
      o.acc_cyc = cyc;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         i_req_vld = 1'b0; i_pkt_out_rdy = 1'b0; i_rsp_rdy = 1'b0;
         if (pkt_hs) begin pkt_done = 1; pkt_hs = 0; mem_armed = !we; end
         if (rsp_hs) begin rsp_done = 1; rsp_hs = 0; end
         if (in_hs)  begin mem_done = 1; in_hs = 0; i_pkt_in_vld = 1'b0; end
         if (o_req_rdy && (!rsp_done || (mem_armed && !mem_done))) o.rdy_busy++;
         if (o_pkt_in_rdy && (!pkt_done || we)) o.inrdy_bad++;
         if (o_pkt_out_vld) begin
            if (pkt_done || (o.pkt_cyc >= 0 && o_pkt_out !== o.pkt)) o.unstable++;
            if (o.pkt_cyc < 0) begin o.pkt_cyc = cyc; o.pkt = o_pkt_out; end
            if (!pkt_done) begin
               if (pw == pdly) begin i_pkt_out_rdy = 1'b1; pkt_hs = 1; end
               else pw++;
            end
         end
         if (o_rsp_vld) begin
            if (rsp_done || (o.rsp_cyc >= 0 &&
                {o_rsp_rdata, o_rsp_misaligned, o_rsp_err} !== {o.rdata, o.mis, o.err}))
               o.unstable++;
            if (o.rsp_cyc < 0) begin
               o.rsp_cyc = cyc; o.rdata = o_rsp_rdata; o.mis = o_rsp_misaligned; o.err = o_rsp_err;
            end
            if (!rsp_done) begin
               if (cw == cdly) begin i_rsp_rdy = 1'b1; rsp_hs = 1; end
               else cw++;
            end
         end
         if (mem_armed && !mem_done) begin
            if (!i_pkt_in_vld) begin
               if (mw == mdly) begin
                  i_pkt_in_vld = 1'b1;
                  i_pkt_in = '{mtype: MEM_READ, addr: addr, len: f3[1:0], data: md};
               end else mw++;
            end
            if (o.rsp_cyc >= 0 && o.err && !o_pkt_in_rdy) o.inrdy_bad++;
            if (i_pkt_in_vld && o_pkt_in_rdy) begin in_hs = 1; o.late = (o.rsp_cyc >= 0); end
         end
         if (rsp_done && !(mem_armed && !mem_done)) begin
            o.done = 1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      n_vec++;
      if ({o_req_rdy, o_rsp_vld, o_pkt_out_vld, o_pkt_in_rdy, o_rsp_misaligned, o_rsp_err} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 100000",
                  {o_req_rdy, o_rsp_vld, o_pkt_out_vld, o_pkt_in_rdy, o_rsp_misaligned, o_rsp_err});
      end
      n_vec++;
      if (o_pkt_out !== '0 || o_rsp_rdata !== 32'd0) begin
         n_err++;
         $display("FAIL reset_data: got pkt %h rdata %h expected 0", o_pkt_out, o_rsp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (o_req_rdy !== 1'b1 || o_pkt_in_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: got rdy %b in_rdy %b expected 1 0", o_req_rdy, o_pkt_in_rdy);
      end
   endtask

   task automatic test_store();
      obs_t o;
      mem_pkt_t ep;
      run_txn(1'b1, 32'h0, 3'd2, 32'hDEADBEEF, 32'h0, 0, 0, 0, o);
      ep = '{mtype: MEM_WRITE, addr: 32'h0, len: 2'd2, data: 32'hDEADBEEF};
      n_vec++;
      if (o.pkt_cyc !== o.acc_cyc + 1 || o.pkt !== ep) begin
         n_err++;
         $display("FAIL store_pkt: got cyc %0d pkt %h expected cyc %0d pkt %h", o.pkt_cyc, o.pkt, o.acc_cyc + 1, ep);
      end
      n_vec++;
      if (!o.done || o.rsp_cyc !== o.acc_cyc + 2 || o.rdata !== 32'd0 || o.err || o.mis) begin
         n_err++;
         $display("FAIL store_rsp: got cyc %0d rdata %h expected cyc %0d rdata 0", o.rsp_cyc, o.rdata, o.acc_cyc + 2);
      end
   endtask

   task automatic test_load_ext();
      obs_t o;
      logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b001};
      logic [31:0] ads [3] = '{32'h1, 32'h1, 32'h2};
      logic [31:0] mds [3] = '{32'h80, 32'h80, 32'h7FFF};
      logic [31:0] exs [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00007FFF};
      for (int i = 0; i < 3; i++) begin
         run_txn(1'b0, ads[i], f3s[i], 32'h0, mds[i], 0, 1, 0, o);
         n_vec++;
         if (!o.done || o.rdata !== exs[i] || o.err) begin
            n_err++;
            $display("FAIL load_ext_%0d: got rdata %h err %b expected %h", i, o.rdata, o.err, exs[i]);
         end
         n_vec++;
         if (o.pkt.mtype !== MEM_READ || o.pkt.data !== 32'd0 || o.pkt.len !== f3s[i][1:0] ||
             o.rsp_cyc !== m_rsp_cyc(1'b0, 0, o.acc_cyc, 0, 1)) begin
            n_err++;
            $display("FAIL load_pkt_%0d: got pkt %h rsp_cyc %0d expected rsp_cyc %0d", i, o.pkt, o.rsp_cyc,
                     m_rsp_cyc(1'b0, 0, o.acc_cyc, 0, 1));
         end
      end
   endtask

   task automatic test_misaligned();
      obs_t o;
      logic [31:0] ads [3] = '{32'h2, 32'h3, 32'h4};
      logic [2:0]  f3s [3] = '{3'd2, 3'd1, 3'd2};
      for (int i = 0; i < 3; i++) begin
         run_txn(1'b0, ads[i], f3s[i], 32'h0, 32'h12345678, 0, 0, 0, o);
         n_vec++;
         if (!o.done || (o.pkt_cyc >= 0) !== (i == 2) || o.mis !== (i != 2) ||
             o.rsp_cyc !== m_rsp_cyc(1'b0, i != 2, o.acc_cyc, 0, 0)) begin
            n_err++;
            $display("FAIL misalign_%0d: got pkt_cyc %0d mis %b rsp_cyc %0d expected mis %b rsp_cyc %0d", i,
                     o.pkt_cyc, o.mis, o.rsp_cyc, i != 2, m_rsp_cyc(1'b0, i != 2, o.acc_cyc, 0, 0));
         end
      end
   endtask

   task automatic test_backpressure();
      obs_t o;
      for (int i = 0; i < 2; i++) begin
         run_txn(i == 0, 32'h100, 3'd2, 32'hA5A5_0F0F, 32'h89ABCDEF, 5, 0, 3, o);
         n_vec++;
         if (o.unstable !== 0 || o.rdy_busy !== 0 || o.inrdy_bad !== 0) begin
            n_err++;
            $display("FAIL backpressure_%0d: got unstable %0d rdy_busy %0d inrdy_bad %0d expected 0 0 0", i,
                     o.unstable, o.rdy_busy, o.inrdy_bad);
         end
         n_vec++;
         if (!o.done || o.rsp_cyc !== m_rsp_cyc(i == 0, 0, o.acc_cyc, 5, 0) ||
             o.rdata !== ((i == 0) ? 32'd0 : 32'h89ABCDEF)) begin
            n_err++;
            $display("FAIL backpressure_rsp_%0d: got cyc %0d rdata %h expected cyc %0d", i, o.rsp_cyc, o.rdata,
                     m_rsp_cyc(i == 0, 0, o.acc_cyc, 5, 0));
         end
      end
   endtask

   task automatic test_timeout_drain();
      obs_t o;
      run_txn(1'b0, 32'h10, 3'd2, 32'h0, 32'h55AA55AA, 0, 8, 0, o);
      n_vec++;
      if (!o.done || o.err !== 1'b1 || o.rdata !== 32'd0 || o.rsp_cyc !== o.acc_cyc + 2 + TO) begin
         n_err++;
         $display("FAIL timeout: got err %b rdata %h cyc %0d expected err 1 rdata 0 cyc %0d", o.err, o.rdata,
                  o.rsp_cyc, o.acc_cyc + 2 + TO);
      end
      n_vec++;
      if (!o.late || o.rdy_busy !== 0 || o.inrdy_bad !== 0) begin
         n_err++;
         $display("FAIL drain: got late %b rdy_busy %0d inrdy_bad %0d expected 1 0 0", o.late, o.rdy_busy, o.inrdy_bad);
      end
      run_txn(1'b0, 32'h14, 3'd2, 32'h0, 32'h0BADF00D, 0, TO - 1, 0, o);
      n_vec++;
      if (!o.done || o.err !== 1'b0 || o.rdata !== 32'h0BADF00D || o.late) begin
         n_err++;
         $display("FAIL timeout_edge: got err %b rdata %h late %b expected err 0 rdata 0badf00d late 0", o.err, o.rdata, o.late);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      @(negedge clk);
      i_req_vld = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h40; i_req_funct3 = 3'd2;
      for (int k = 0; k < 20 && !o_req_rdy; k++) @(negedge clk);
      @(negedge clk);
      i_req_vld = 1'b0; i_pkt_out_rdy = 1'b1;
      @(negedge clk);
      i_pkt_out_rdy = 1'b0;
      @(negedge clk);
      n_vec++;
      if (o_pkt_in_rdy !== 1'b1 || o_req_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL mid_wait: got in_rdy %b req_rdy %b expected 1 0", o_pkt_in_rdy, o_req_rdy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({o_req_rdy, o_rsp_vld, o_pkt_out_vld, o_pkt_in_rdy, o_rsp_misaligned, o_rsp_err} !== 6'b100000 ||
          o_pkt_out !== '0 || o_rsp_rdata !== 32'd0) begin
         n_err++;
         $display("FAIL mid_reset: got flags %b pkt %h expected 100000 0",
                  {o_req_rdy, o_rsp_vld, o_pkt_out_vld, o_pkt_in_rdy, o_rsp_misaligned, o_rsp_err}, o_pkt_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(1'b0, 32'h40, 3'd2, 32'h0, 32'hCAFEF00D, 0, 2, 0, o);
      n_vec++;
      if (!o.done || o.rdata !== 32'hCAFEF00D || o.err || o.rsp_cyc !== m_rsp_cyc(1'b0, 0, o.acc_cyc, 0, 2)) begin
         n_err++;
         $display("FAIL after_reset_lw: got rdata %h err %b cyc %0d expected cafef00d 0 %0d", o.rdata, o.err,
                  o.rsp_cyc, m_rsp_cyc(1'b0, 0, o.acc_cyc, 0, 2));
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wd, md, erd;
      int          pdly, mdly, cdly;
      bit          mis, tmo;
      mem_pkt_t    ep;
      for (int i = 0; i < 40; i++) begin
         we   = 1'($urandom_range(0, 1));
         f3   = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr - (addr % (1 << f3[1:0]));
         wd   = $urandom;
         md   = $urandom;
         pdly = $urandom_range(0, 3);
         mdly = $urandom_range(0, 6);
         cdly = $urandom_range(0, 2);
         run_txn(we, addr, f3, wd, md, pdly, mdly, cdly, o);
         mis = m_misaligned(addr, f3);
         tmo = !mis && !we && (mdly >= TO);
         erd = (mis || we || tmo) ? 32'd0 : m_extend(f3, md);
         ep  = '{mtype: we ? MEM_WRITE : MEM_READ, addr: addr, len: f3[1:0], data: we ? wd : 32'd0};
         n_vec++;
         if (!o.done || o.rsp_cyc !== m_rsp_cyc(we, mis, o.acc_cyc, pdly, mdly)) begin
            n_err++;
            $display("FAIL rand_%0d_latency: got done %b cyc %0d expected cyc %0d", i, o.done, o.rsp_cyc,
                     m_rsp_cyc(we, mis, o.acc_cyc, pdly, mdly));
         end
         n_vec++;
         if ({o.rdata, o.mis, o.err} !== {erd, mis, tmo}) begin
            n_err++;
            $display("FAIL rand_%0d_rsp: got rdata %h mis %b err %b expected %h %b %b", i, o.rdata, o.mis,
                     o.err, erd, mis, tmo);
         end
         n_vec++;
         if (mis ? (o.pkt_cyc >= 0) : (o.pkt_cyc !== o.acc_cyc + 1 || o.pkt !== ep)) begin
            n_err++;
            $display("FAIL rand_%0d_pkt: got cyc %0d pkt %h expected pkt %h (issued %b)", i, o.pkt_cyc, o.pkt, ep, !mis);
         end
         n_vec++;
         if (o.unstable !== 0 || o.rdy_busy !== 0 || o.inrdy_bad !== 0 || o.late !== tmo) begin
            n_err++;
            $display("FAIL rand_%0d_proto: got unstable %0d rdy_busy %0d inrdy_bad %0d late %b expected 0 0 0 %b",
                     i, o.unstable, o.rdy_busy, o.inrdy_bad, o.late, tmo);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      i_req_vld = 1'b0; i_req_we = 1'b0; i_req_addr = 32'd0; i_req_funct3 = 3'd0; i_req_wdata = 32'd0;
      i_rsp_rdy = 1'b0; i_pkt_out_rdy = 1'b0; i_pkt_in_vld = 1'b0; i_pkt_in = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_store();
      test_load_ext();
      test_misaligned();
      test_backpressure();
      test_timeout_drain();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
